result_rf_sequencer: RTL and testbench
======================================

Name: result_rf_sequencer

Overview:
- Layer-level controller that drives the result register file for one convolution layer.
- Per output channel it:
  - fetches that channel's bias from a synchronous bias ROM;
  - issues a bias_init pulse;
  - accepts the conv engine's per-pixel results over a valid/ready handshake and turns each into a store at the matching address;
  - optionally issues a relu pulse.
- After the last channel it pulses done so the register file dumps its contents, and signals layer completion upstream.

Parameters:
- NUM_OUT_CH, 8, number of output channels processed per layer (1..16).
- PIXELS_PER_CH, 63, results stored per channel; rf_addr runs 0..PIXELS_PER_CH-1.
- DATA_W, 8, width of bias and result values.
- ADDR_W, 10, width of rf_addr.
- CH_W, 4, width of channel index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a layer; sampled only in IDLE.
- relu_en  in  1  apply ReLU per channel; latched when start is accepted.
- busy  out  1  high from start acceptance until the cycle after the layer_done pulse.
- layer_done  out  1  one-cycle pulse, coincident with rf_done.
- bias_rd_addr  out  CH_W  bias ROM address (= current channel).
- bias_rd_data  in  DATA_W  bias ROM data, valid 1 cycle after address.
- res_valid  in  1  conv result valid.
- res_data  in  DATA_W  conv result (signed).
- res_ready  out  1  sequencer can accept a result.
- rf_store  out  1  store pulse to the register file.
- rf_bias_init  out  1  bias_init pulse.
- rf_relu  out  1  relu pulse.
- rf_done  out  1  done pulse.
- rf_out_c  out  CH_W  current output channel.
- rf_bias  out  DATA_W  bias value accompanying rf_bias_init.
- rf_value  out  DATA_W  value accompanying rf_store.
- rf_addr  out  ADDR_W  address accompanying rf_store.

Behaviour:
- Reset: all outputs are registered and return to 0; state is IDLE; channel and pixel counters are 0.
  - Reset mid-layer aborts immediately with no rf_done or layer_done.
- State machine: IDLE -> BIAS_RD -> BIAS_WAIT -> BIAS_INIT -> STREAM -> [RELU] -> NEXT -> (BIAS_RD | FINISH) -> IDLE.
- IDLE:
  - start=1 at edge E: latch relu_en, ch=0, busy=1 from E, go to BIAS_RD.
  - start while busy is ignored.
- BIAS_RD: bias_rd_addr=ch (held through BIAS_INIT).
- BIAS_WAIT: one-cycle ROM latency.
- BIAS_INIT: capture bias_rd_data; next cycle rf_bias_init=1 for exactly 1 cycle, with rf_bias=that data and rf_out_c=ch.
- STREAM:
  - res_ready=1 only in this state; pixel counter px starts at 0.
  - Each cycle with res_valid&res_ready: the next cycle has rf_store=1, rf_value=res_data, rf_addr=px, rf_out_c=ch; then px increments.
  - Back-to-back accepts give back-to-back stores; res_valid low gives no store.
  - On the accept where px==PIXELS_PER_CH-1: res_ready drops the next cycle and px clears to 0. Go to RELU if relu_en was latched, else NEXT.
  - res_valid outside STREAM is ignored; nothing is consumed.
- RELU: rf_relu=1 for 1 cycle, rf_out_c=ch. It is asserted exactly 1 cycle after the last rf_store of the channel, never overlapping it.
- NEXT:
  - If ch==NUM_OUT_CH-1, go to FINISH.
  - Else ch++ and go to BIAS_RD.
- FINISH: rf_done=1 and layer_done=1 together for 1 cycle; busy deasserts the following cycle; return to IDLE.
- Mutual exclusion: at most one of rf_store, rf_bias_init, rf_relu, rf_done is high in any cycle.
- rf_out_c holds ch constant from rf_bias_init through rf_relu of that channel.
- Data path: rf_value and rf_bias pass through unmodified (no arithmetic).
- Address width: rf_addr zero-extends px to ADDR_W. PIXELS_PER_CH must be <= 2^ADDR_W; the counter never wraps past PIXELS_PER_CH-1.
- Edge case NUM_OUT_CH=1: single channel pass, then FINISH.
- Edge case PIXELS_PER_CH=1: one store per channel.

Test Plan:
- Basic layer, NUM_OUT_CH=2, PIXELS_PER_CH=4, relu_en=1, ROM[0]=5, ROM[1]=7, res_valid held high with data 10,-8,3,0 then 1,2,3,4 -> per channel: rf_bias_init (rf_bias=5 then 7), 4 consecutive rf_store at addr 0..3 with matching values, then rf_relu; then rf_done and layer_done together once; busy low afterwards.
- Same run with relu_en=0 -> identical store and bias sequence, rf_relu never asserted.
- Stalling producer: res_valid toggles 1,0,0,1,1,0,1 -> stores only on the cycle after each accept, addresses contiguous 0..3, no duplicate or missing store.
- Reset asserted during channel 1 STREAM after 2 stores -> all outputs 0 in the same cycle, no rf_done; a fresh start afterwards runs a full layer from ch=0, addr 0.
- start pulsed again mid-layer, and res_valid=1 during BIAS_RD/RELU -> both ignored: res_ready=0 in those states, total stores = NUM_OUT_CH*PIXELS_PER_CH.
- Protocol checker over all runs: at most one rf_* pulse per cycle; rf_out_c stable within a channel; rf_relu exactly 1 cycle after the last store.

Source files
------------

// File: rtl/result_rf_sequencer_if.sv
// Sequencer-side bundle: layer control, bias ROM read port, conv result
// handshake and the result register-file command bus.
interface result_rf_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CH_W   = 4
);
    logic              start;
    logic              relu_en;
    logic              busy;
    logic              layer_done;
    logic [CH_W-1:0]   bias_rd_addr;
    logic [DATA_W-1:0] bias_rd_data;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              rf_store;
    logic              rf_bias_init;
    logic              rf_relu;
    logic              rf_done;
    logic [CH_W-1:0]   rf_out_c;
    logic [DATA_W-1:0] rf_bias;
    logic [DATA_W-1:0] rf_value;
    logic [ADDR_W-1:0] rf_addr;

    // Sequencer side
    modport master (
        input  start, relu_en, bias_rd_data, res_valid, res_data,
        output busy, layer_done, bias_rd_addr, res_ready,
               rf_store, rf_bias_init, rf_relu, rf_done,
               rf_out_c, rf_bias, rf_value, rf_addr
    );

    // Environment side (controller, bias ROM, conv engine, register file)
    modport slave (
        output start, relu_en, bias_rd_data, res_valid, res_data,
        input  busy, layer_done, bias_rd_addr, res_ready,
               rf_store, rf_bias_init, rf_relu, rf_done,
               rf_out_c, rf_bias, rf_value, rf_addr
    );
endinterface

// File: rtl/result_rf_sequencer.sv
// Layer-level controller for the result register file: per output channel
// fetch bias, pulse bias_init, stream conv results into stores, optional
// relu pulse; after the last channel pulse done/layer_done.
// Every output is driven straight from a register.
module result_rf_sequencer #(
    parameter int unsigned NUM_OUT_CH    = 8,
    parameter int unsigned PIXELS_PER_CH = 63,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned CH_W          = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    result_rf_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS_RD,
        S_BIAS_WAIT,
        S_BIAS_INIT,
        S_STREAM,
        S_RELU,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] PX_LAST = ADDR_W'(PIXELS_PER_CH - 1);
    localparam logic [CH_W-1:0]   CH_LAST = CH_W'(NUM_OUT_CH - 1);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] px_q, px_d;
    logic              relu_lat_q, relu_lat_d;
    logic              busy_q, busy_d;
    logic [CH_W-1:0]   bias_addr_q, bias_addr_d;
    logic              res_ready_q, res_ready_d;
    logic              store_q, store_d;
    logic              bias_init_q, bias_init_d;
    logic              relu_q, relu_d;
    logic              done_q, done_d;
    logic [CH_W-1:0]   out_c_q, out_c_d;
    logic [DATA_W-1:0] bias_q, bias_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Next-state and registered-output computation for the layer FSM
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        px_d        = px_q;
        relu_lat_d  = relu_lat_q;
        busy_d      = busy_q;
        bias_addr_d = bias_addr_q;
        res_ready_d = 1'b0;
        store_d     = 1'b0;
        bias_init_d = 1'b0;
        relu_d      = 1'b0;
        done_d      = 1'b0;
        out_c_d     = out_c_q;
        bias_d      = bias_q;
        value_d     = value_q;
        addr_d      = addr_q;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    busy_d      = 1'b1;
                    relu_lat_d  = bus.relu_en;
                    ch_d        = '0;
                    px_d        = '0;
                    bias_addr_d = '0;
                    state_d     = S_BIAS_RD;
                end
            end
            S_BIAS_RD:   state_d = S_BIAS_WAIT;
            S_BIAS_WAIT: state_d = S_BIAS_INIT;
            S_BIAS_INIT: begin
                // ROM data for bias_addr_q is stable here; the pulse and the
                // opening of res_ready both appear in the first STREAM cycle.
                bias_d      = bus.bias_rd_data;
                bias_init_d = 1'b1;
                out_c_d     = ch_q;
                px_d        = '0;
                res_ready_d = 1'b1;
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                res_ready_d = 1'b1;
                if (bus.res_valid && res_ready_q) begin
                    store_d = 1'b1;
                    value_d = bus.res_data;
                    addr_d  = px_q;
                    out_c_d = ch_q;
                    if (px_q == PX_LAST) begin
                        px_d        = '0;
                        res_ready_d = 1'b0;
                        state_d     = relu_lat_q ? S_RELU : S_NEXT;
                    end else begin
                        px_d = px_q + ADDR_W'(1);
                    end
                end
            end
            S_RELU: begin
                relu_d  = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (ch_q == CH_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    ch_d        = ch_q + CH_W'(1);
                    bias_addr_d = ch_q + CH_W'(1);
                    state_d     = S_BIAS_RD;
                end
            end
            S_FINISH: begin
                // busy stays high through the done cycle and drops in IDLE
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            px_q        <= '0;
            relu_lat_q  <= 1'b0;
            busy_q      <= 1'b0;
            bias_addr_q <= '0;
            res_ready_q <= 1'b0;
            store_q     <= 1'b0;
            bias_init_q <= 1'b0;
            relu_q      <= 1'b0;
            done_q      <= 1'b0;
            out_c_q     <= '0;
            bias_q      <= '0;
            value_q     <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            px_q        <= px_d;
            relu_lat_q  <= relu_lat_d;
            busy_q      <= busy_d;
            bias_addr_q <= bias_addr_d;
            res_ready_q <= res_ready_d;
            store_q     <= store_d;
            bias_init_q <= bias_init_d;
            relu_q      <= relu_d;
            done_q      <= done_d;
            out_c_q     <= out_c_d;
            bias_q      <= bias_d;
            value_q     <= value_d;
            addr_q      <= addr_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.layer_done   = done_q;
    assign bus.bias_rd_addr = bias_addr_q;
    assign bus.res_ready    = res_ready_q;
    assign bus.rf_store     = store_q;
    assign bus.rf_bias_init = bias_init_q;
    assign bus.rf_relu      = relu_q;
    assign bus.rf_done      = done_q;
    assign bus.rf_out_c     = out_c_q;
    assign bus.rf_bias      = bias_q;
    assign bus.rf_value     = value_q;
    assign bus.rf_addr      = addr_q;

endmodule

// File: tb/tb_result_rf_sequencer.sv
// Directed bench for result_rf_sequencer with 2 channels x 4 pixels.
module tb_result_rf_sequencer;

    localparam int unsigned NCH = 2;
    localparam int unsigned NPX = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 10;
    localparam int unsigned CW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    result_rf_sequencer_if #(.DATA_W(DW), .ADDR_W(AW), .CH_W(CW)) bus ();

    result_rf_sequencer #(
        .NUM_OUT_CH(NCH), .PIXELS_PER_CH(NPX),
        .DATA_W(DW), .ADDR_W(AW), .CH_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Synchronous bias ROM
    logic [DW-1:0] rom [16];
    always @(posedge clk) bus.bias_rd_data <= rom[bus.bias_rd_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [40:0] outs;
    always_comb outs = {bus.busy, bus.layer_done, bus.bias_rd_addr, bus.res_ready,
                        bus.rf_store, bus.rf_bias_init, bus.rf_relu, bus.rf_done,
                        bus.rf_out_c, bus.rf_bias, bus.rf_value, bus.rf_addr};

    // Cycle count, advanced on every rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs rf_* events and checks protocol rules on the falling edge
    logic [31:0]   store_log [$];
    int            store_cyc [$];
    logic [31:0]   bias_log [$];
    int            relu_cnt = 0;
    int            done_cnt = 0;
    logic          prev_store = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [CW-1:0] cur_ch = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_store <= 1'b0;
        end else begin
            if (bus.rf_store | bus.rf_bias_init | bus.rf_relu | bus.rf_done)
                chk("one_pulse", $countones({bus.rf_store, bus.rf_bias_init, bus.rf_relu, bus.rf_done}), 1);
            if (bus.rf_done) begin
                chk("layer_done_with_rf_done", bus.layer_done, 1);
                done_cnt <= done_cnt + 1;
            end
            if (bus.layer_done)
                chk("rf_done_with_layer_done", bus.rf_done, 1);
            if (bus.rf_bias_init) begin
                bias_log.push_back({20'd0, bus.rf_out_c, bus.rf_bias});
                cur_ch <= bus.rf_out_c;
            end
            if (bus.rf_store) begin
                chk("store_ch_stable", bus.rf_out_c, cur_ch);
                store_log.push_back({10'd0, bus.rf_out_c, bus.rf_addr, bus.rf_value});
                store_cyc.push_back(cyc);
            end
            if (bus.rf_relu) begin
                relu_cnt <= relu_cnt + 1;
                chk("relu_after_last_store", {prev_store, prev_addr}, {1'b1, AW'(NPX - 1)});
                chk("relu_ch_stable", bus.rf_out_c, cur_ch);
            end
            prev_store <= bus.rf_store;
            prev_addr  <= bus.rf_addr;
        end
    end

    logic [DW-1:0] exp_data [8] = '{8'd10, 8'hF8, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    int acc_edge [$];
    int sb, bb, rb, db;

    task automatic mark();
        sb = store_log.size();
        bb = bias_log.size();
        rb = relu_cnt;
        db = done_cnt;
        acc_edge.delete();
    endtask

    // Start a layer and feed results until layer_done (or abort point / budget)
    task automatic run_layer(input bit relu, input bit stall, input bit poke, input int abort_at);
        int  idx;
        bit  seen;
        bit  stop;
        bit  acc;
        bit  v;
        bit  pat [7];
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        idx  = 0;
        seen = 1'b0;
        stop = 1'b0;
        @(negedge clk); #1;
        bus.start   = 1'b1;
        bus.relu_en = relu;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.relu_en = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        for (int c = 0; c < 300 && !stop; c++) begin
            v             = stall ? pat[c % 7] : 1'b1;
            bus.res_valid = v;
            bus.res_data  = (idx < 8) ? exp_data[idx] : 8'h00;
            bus.start     = poke && (c % 5 == 2);
            acc           = v && bus.res_ready;
            if (acc) acc_edge.push_back(cyc + 1);
            @(posedge clk); #1;
            if (acc) idx++;
            @(negedge clk); #1;
            if (bus.layer_done) begin
                seen = 1'b1;
                stop = 1'b1;
                chk("busy_during_done", bus.busy, 1);
            end
            if (abort_at > 0 && store_log.size() - sb >= abort_at) stop = 1'b1;
        end
        bus.start = 1'b0;
        if (abort_at == 0) begin
            bus.res_valid = 1'b0;
            chk("layer_done_seen", seen, 1);
        end
    endtask

    // Compare everything logged since mark() against the hand-computed layer
    task automatic check_layer(input bit relu);
        logic [63:0] o;
        logic [63:0] e;
        @(posedge clk); #1;
        chk("busy_after_done", bus.busy, 0);
        chk("store_count", store_log.size() - sb, NCH * NPX);
        for (int i = 0; i < 8; i++) begin
            o = (sb + i < store_log.size()) ? 64'(store_log[sb + i]) : '1;
            chk($sformatf("store%0d", i), o, {CW'(i / NPX), AW'(i % NPX), exp_data[i]});
            o = (sb + i < store_cyc.size()) ? 64'(store_cyc[sb + i]) : '1;
            e = (i < acc_edge.size()) ? 64'(acc_edge[i]) : '0;
            chk($sformatf("store%0d_timing", i), o, e);
        end
        chk("bias_init_count", bias_log.size() - bb, NCH);
        o = (bb < bias_log.size()) ? 64'(bias_log[bb]) : '1;
        chk("bias_ch0", o, {CW'(0), 8'd5});
        o = (bb + 1 < bias_log.size()) ? 64'(bias_log[bb + 1]) : '1;
        chk("bias_ch1", o, {CW'(1), 8'd7});
        chk("relu_count", relu_cnt - rb, relu ? NCH : 0);
        chk("done_count", done_cnt - db, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h55;
        rom[0] = 8'd5;
        rom[1] = 8'd7;
        bus.start     = 1'b0;
        bus.relu_en   = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;

        #1 rst = 1'b1;
        #10;
        chk("reset_outputs", outs, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_outputs", outs, 0);

        // Basic layer with relu, valid held high
        mark();
        run_layer(1'b1, 1'b0, 1'b0, 0);
        check_layer(1'b1);

        // Same layer without relu
        mark();
        run_layer(1'b0, 1'b0, 1'b0, 0);
        check_layer(1'b0);

        // Stalling producer
        mark();
        run_layer(1'b1, 1'b1, 1'b0, 0);
        check_layer(1'b1);

        // start pulsed while busy, valid high outside STREAM
        mark();
        run_layer(1'b1, 1'b0, 1'b1, 0);
        check_layer(1'b1);

        // Reset during channel 1 stream after two of its stores
        mark();
        run_layer(1'b1, 1'b0, 1'b0, NPX + 2);
        rst = 1'b1;
        #1;
        chk("abort_outputs_zero", outs, 0);
        chk("abort_no_done", done_cnt - db, 0);
        bus.res_valid = 1'b0;
        @(negedge clk); #1;
        chk("abort_still_no_done", done_cnt - db, 0);
        rst = 1'b0;
        @(negedge clk); #1;

        // Fresh layer after abort restarts from channel 0, address 0
        mark();
        run_layer(1'b1, 1'b0, 1'b0, 0);
        check_layer(1'b1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
